// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating signed dot-product accumulator with start/len command and valid/ready ports
module mac_accumulator #(
    parameter int W     = 32,
    parameter int ACC_W = 72,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [2*W-1:0]   product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    overflow,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    state;
    state_t                    state_next;
    logic signed [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]          remaining;
    logic                      ovf;

    logic                      launch;
    logic                      accept;
    logic                      last_term;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic                      pos_ovf;
    logic                      neg_ovf;

    assign launch    = (state == S_IDLE) && start;
    assign accept    = (state == S_ACCUM) && in_valid;
    assign last_term = (remaining == LEN_W'(1));

    // Sign extension comes from the signed product port.
    assign prod_ext = ACC_W'(product);
    assign sum      = acc + prod_ext;
    assign pos_ovf  = !acc[ACC_W-1] && !prod_ext[ACC_W-1] &&  sum[ACC_W-1];
    assign neg_ovf  =  acc[ACC_W-1] &&  prod_ext[ACC_W-1] && !sum[ACC_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid && last_term) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: cleared on launch, updated once per accepted product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
        end else if (launch) begin
            acc       <= '0;
            remaining <= len;
            ovf       <= 1'b0;
        end else if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (pos_ovf) begin
                acc <= SAT_POS;
                ovf <= 1'b1;
            end else if (neg_ovf) begin
                acc <= SAT_NEG;
                ovf <= 1'b1;
            end else begin
                acc <= sum;
            end
        end
    end

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign acc_out   = acc;
    assign overflow  = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized and directed self-checking bench for mac_accumulator
module tb_mac_accumulator;

    localparam int W     = 32;
    localparam int ACC_W = 64;
    localparam int LEN_W = 16;
    localparam logic signed [127:0] MAXV = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (ACC_W-1));

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        len = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [2*W-1:0]   product = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] acc_out;
    logic                    overflow;
    logic                    busy;

    int checks = 0;
    int failures = 0;
    logic signed [2*W-1:0] prod_q[$];

    mac_accumulator #(.W(W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .product(product),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one job from prod_q; mode 0 = streaming, 1 = one idle cycle between terms, 2 = random gaps.
    task automatic run_job(input int n, input int mode, output int cyc, output bit to);
        int idx;
        int guard;
        bit gap;
        bit take;
        start = 1'b1;
        len = LEN_W'(n);
        in_valid = 1'b0;
        step();
        start = 1'b0;
        cyc = 0; idx = 0; guard = 0; gap = 1'b0; to = 1'b0;
        while (idx < n && guard < 500) begin
            if (mode == 1 && gap) begin
                in_valid = 1'b0;
                gap = 1'b0;
            end else if (mode == 2) begin
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b1;
            end
            product = in_valid ? prod_q[idx] : {$urandom, $urandom};
            take = in_valid && in_ready;
            step();
            cyc++; guard++;
            if (take) begin
                idx++;
                gap = (mode == 1);
            end
        end
        in_valid = 1'b0;
        while (!out_valid && guard < 500) begin
            step();
            cyc++; guard++;
        end
        if (!out_valid) to = 1'b1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid, busy, overflow} !== 4'b0000 || acc_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b ovf=%b acc=%0d, want all 0",
                     in_ready, out_valid, busy, overflow, acc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_sum();
        int cyc;
        bit to;
        prod_q = '{64'sd150, -64'sd300, 64'sd64, 64'sd0};
        run_job(4, 0, cyc, to);
        checks++;
        if (to || cyc != 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles (timeout=%0b), want 4", cyc, to);
        end
        checks++;
        if (acc_out !== -64'sd86 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_sum: got acc=%0d ovf=%b, want -86 ovf=0", acc_out, overflow);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_handshake: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_bubbles();
        int cyc;
        bit to;
        prod_q = '{64'sd15, 64'sd10, -64'sd8};
        run_job(3, 1, cyc, to);
        checks++;
        if (to || cyc != 5 || acc_out !== 64'sd17) begin
            failures++;
            $display("FAIL bubbles: got acc=%0d after %0d cycles, want 17 after 5", acc_out, cyc);
        end
        consume();
    endtask

    task automatic test_zero_length();
        int cyc;
        bit to;
        prod_q.delete();
        run_job(0, 0, cyc, to);
        checks++;
        if (to || cyc != 0 || acc_out !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_length: got acc=%0d cycles=%0d in_ready=%b, want 0 0 0", acc_out, cyc, in_ready);
        end
        consume();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_length_idle: got in_ready=%b busy=%b, want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit to;
        prod_q = '{64'sd1000, -64'sd1};
        run_job(2, 0, cyc, to);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            len = 16'd5;
            in_valid = (i != 1);
            product = 64'sd777;
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 64'sd999) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b rdy=%b acc=%0d, want 1 0 999",
                         i, out_valid, in_ready, acc_out);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got ov=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        bit to;
        prod_q = '{64'sh4000_0000_0000_0000, 64'sh4000_0000_0000_0000};
        run_job(2, 0, cyc, to);
        checks++;
        if (to || acc_out !== 64'sh7FFF_FFFF_FFFF_FFFF || overflow !== 1'b1) begin
            failures++;
            $display("FAIL saturation: got acc=%0d ovf=%b, want 9223372036854775807 ovf=1", acc_out, overflow);
        end
        consume();
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky_idle: got ovf=%b, want 1", overflow);
        end
        start = 1'b1;
        len = 16'd1;
        step();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || acc_out !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL overflow_clear: got ovf=%b acc=%0d rdy=%b, want 0 0 1", overflow, acc_out, in_ready);
        end
        in_valid = 1'b1;
        product = 64'sd5;
        step();
        in_valid = 1'b0;
        consume();
    endtask

    task automatic test_async_reset();
        int cyc;
        bit to;
        start = 1'b1;
        len = 16'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        product = 64'sd100;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, overflow} !== 4'b0000 || acc_out !== '0) begin
            failures++;
            $display("FAIL async_reset: got rdy=%b ov=%b busy=%b ovf=%b acc=%0d, want all 0",
                     in_ready, out_valid, busy, overflow, acc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        prod_q = '{64'sd64};
        run_job(1, 0, cyc, to);
        checks++;
        if (to || cyc != 1 || acc_out !== 64'sd64) begin
            failures++;
            $display("FAIL post_reset_job: got acc=%0d cycles=%0d, want 64 after 1", acc_out, cyc);
        end
        consume();
    endtask

    // Reference: exact wide sum clamped to the ACC_W range after every term, sticky flag on any clamp.
    task automatic test_random();
        int cyc;
        bit to;
        int n;
        logic signed [127:0] e;
        logic signed [63:0] p;
        bit e_ovf;
        for (int j = 0; j < 30; j++) begin
            n = $urandom_range(1, 8);
            prod_q.delete();
            e = 0;
            e_ovf = 1'b0;
            for (int k = 0; k < n; k++) begin
                p = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 0) p = p >>> $urandom_range(0, 62);
                prod_q.push_back(p);
                e = e + 128'(p);
                if (e > MAXV) begin e = MAXV; e_ovf = 1'b1; end
                if (e < MINV) begin e = MINV; e_ovf = 1'b1; end
            end
            run_job(n, 2, cyc, to);
            checks++;
            if (to || acc_out !== e[ACC_W-1:0] || overflow !== e_ovf) begin
                failures++;
                $display("FAIL random_job[%0d]: got acc=%0d ovf=%b timeout=%0b, want acc=%0d ovf=%b",
                         j, acc_out, overflow, to, e, e_ovf);
            end
            for (int d = $urandom_range(0, 2); d > 0; d--) step();
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        prod_q = '{64'sd7, 64'sd8};
        run_job(2, 0, cyc, to);
        consume();
        prod_q = '{-64'sd9};
        run_job(1, 0, cyc, to);
        checks++;
        if (to || cyc != 1 || acc_out !== -64'sd9) begin
            failures++;
            $display("FAIL back_to_back: got acc=%0d cycles=%0d, want -9 after 1", acc_out, cyc);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_bubbles();
        test_zero_length();
        test_backpressure();
        test_saturation();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
